// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port controller: widths, aspect
// encodings, controller states and the conf-to-k mapping.
package sram_pkg;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 5;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    localparam logic [2:0] CONF_X32 = 3'd0;
    localparam logic [2:0] CONF_X16 = 3'd1;
    localparam logic [2:0] CONF_X8  = 3'd2;
    localparam logic [2:0] CONF_X4  = 3'd3;
    localparam logic [2:0] CONF_X2  = 3'd4;
    localparam logic [2:0] CONF_X1  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRECH  = 3'd1,
        ACCESS = 3'd2,
        WRITE  = 3'd3,
        SENSE  = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Reserved encodings fall back to the full-width x32 aspect.
    function automatic logic [2:0] conf_to_k(input logic [2:0] c);
        return (c > CONF_X1) ? 3'd0 : c;
    endfunction

endpackage

// File: rtl/sram_lane_sel.sv
// Lane extraction for narrow reads and lane replication for narrow
// writes; purely combinational.
module sram_lane_sel
    import sram_pkg::*;
(
    input  logic [2:0]        rd_conf,
    input  logic [COL_W-1:0]  col_sel,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic [DATA_W-1:0] lane,
    input  logic [2:0]        wr_conf,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rep
);

    logic [2:0]  rk;
    logic [5:0]  rw;
    logic [4:0]  sh;
    logic [31:0] msk;
    logic [2:0]  wk;
    logic [4:0]  wm;

    always_comb begin
        rk   = conf_to_k(rd_conf);
        rw   = 6'd32 >> rk;
        // col_sel < 2^k, so col_sel * W always stays below 32
        sh   = col_sel << (3'd5 - rk);
        msk  = 32'hFFFF_FFFF >> (6'd32 - rw);
        lane = (arr_rdata >> sh) & msk;
    end

    always_comb begin
        wk  = conf_to_k(wr_conf);
        wm  = 5'((6'd32 >> wk) - 6'd1);
        rep = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rep[i] = wdata[5'(i) & wm];
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request front-end for the configurable-aspect SRAM macro: address
// split, write replication, enable sequencing and read lane extraction.
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int PRECH_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int SENSE_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          conf,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [ROW_W-1:0]    row_addr,
    output logic [COL_W-1:0]    col_sel,
    output logic [2:0]          conf_q,
    output logic [DATA_W-1:0]   bl_wdata,
    output logic                prech_en,
    output logic                wl_en,
    output logic                we_en,
    output logic                sae,
    input  logic [DATA_W-1:0]   arr_rdata
);

    localparam int MAX_PA = (PRECH_CYCLES > ACCESS_CYCLES) ? PRECH_CYCLES : ACCESS_CYCLES;
    localparam int MAX_C  = (MAX_PA > SENSE_CYCLES) ? MAX_PA : SENSE_CYCLES;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             we_q;
    logic             accept;
    logic             last;
    logic             capture;
    logic [2:0]       k_in;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] rep;
    logic             ready_n;
    logic             valid_n;
    logic             prech_n;
    logic             wl_n;
    logic             we_n;
    logic             sae_n;

    sram_lane_sel u_lane (
        .rd_conf   (conf_q),
        .col_sel   (col_sel),
        .arr_rdata (arr_rdata),
        .lane      (lane),
        .wr_conf   (conf),
        .wdata     (req_wdata),
        .rep       (rep)
    );

    assign k_in = conf_to_k(conf);
    assign last = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = PRECH;
                    cnt_n   = CNT_W'(PRECH_CYCLES - 1);
                end
            end
            PRECH: begin
                if (last) begin
                    state_n = we_q ? WRITE : ACCESS;
                    cnt_n   = CNT_W'(ACCESS_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACCESS: begin
                if (last) begin
                    state_n = SENSE;
                    cnt_n   = CNT_W'(SENSE_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WRITE: begin
                if (last) state_n = RESP;
                else      cnt_n   = cnt - 1'b1;
            end
            SENSE: begin
                if (last) begin
                    state_n = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Enables follow the next state so they come straight off flops
        ready_n = (state_n == IDLE);
        valid_n = (state_n == RESP);
        prech_n = (state_n == PRECH);
        wl_n    = (state_n == ACCESS) || (state_n == WRITE) || (state_n == SENSE);
        we_n    = (state_n == WRITE);
        sae_n   = (state_n == SENSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            row_addr   <= '0;
            col_sel    <= '0;
            conf_q     <= '0;
            bl_wdata   <= '0;
            prech_en   <= 1'b0;
            wl_en      <= 1'b0;
            we_en      <= 1'b0;
            sae        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= ready_n;
            resp_valid <= valid_n;
            prech_en   <= prech_n;
            wl_en      <= wl_n;
            we_en      <= we_n;
            sae        <= sae_n;
            if (accept) begin
                conf_q     <= conf;
                we_q       <= req_we;
                row_addr   <= ROW_W'(req_addr >> k_in);
                col_sel    <= COL_W'(req_addr) & ((COL_W'(1) << k_in) - COL_W'(1));
                bl_wdata   <= rep;
                resp_rdata <= '0;
            end
            if (capture) begin
                resp_rdata <= lane;
            end
        end
    end

endmodule
